// File: rtl/control_unit.sv
// Decode stage: turns a SPARC V8 instruction word into a registered
// 19-bit control bundle for the datapath.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] instr,
    output logic [18:0] instr_signals
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_PASS = 4'b1110;

    localparam logic [2:0] SOH_RS2  = 3'b000;
    localparam logic [2:0] SOH_SIMM = 3'b001;
    localparam logic [2:0] SOH_IMM  = 3'b010;
    localparam logic [2:0] SOH_D30  = 3'b011;
    localparam logic [2:0] SOH_D22  = 3'b100;

    localparam logic [31:0] NOP_WORD = 32'h0100_0000;

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic [2:0] soh_i;

    logic       jmpl, call, branch, load;
    logic       rf_we, mem_en, mem_rw, mem_se;
    logic [1:0] mem_size;
    logic [3:0] alu_op;
    logic [2:0] soh_op;
    logic       modify_cc, rd_r15;

    assign op    = instr[31:30];
    assign op2   = instr[24:22];
    assign op3   = instr[24:19];
    assign soh_i = instr[13] ? SOH_SIMM : SOH_RS2;

    always_comb begin
        jmpl      = 1'b0;
        call      = 1'b0;
        branch    = 1'b0;
        load      = 1'b0;
        rf_we     = 1'b0;
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_se    = 1'b0;
        mem_size  = 2'b00;
        alu_op    = ALU_ADD;
        soh_op    = SOH_RS2;
        modify_cc = 1'b0;
        rd_r15    = 1'b0;
        unique case (op)
            2'b01: begin
                call   = 1'b1;
                rf_we  = 1'b1;
                rd_r15 = 1'b1;
                soh_op = SOH_D30;
            end
            2'b00: begin
                if (op2 == 3'b010) begin
                    branch = 1'b1;
                    soh_op = SOH_D22;
                end else if (op2 == 3'b100 && instr != NOP_WORD) begin
                    rf_we  = 1'b1;
                    alu_op = ALU_PASS;
                    soh_op = SOH_IMM;
                end
            end
            2'b10: begin
                unique case (op3)
                    6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                    6'h05, 6'h06, 6'h07, 6'h08, 6'h0C,
                    6'h10, 6'h11, 6'h12, 6'h13, 6'h14,
                    6'h15, 6'h16, 6'h17, 6'h18, 6'h1C: begin
                        rf_we     = 1'b1;
                        alu_op    = op3[3:0];
                        modify_cc = op3[4];
                        soh_op    = soh_i;
                    end
                    6'h25, 6'h26, 6'h27: begin
                        rf_we  = 1'b1;
                        soh_op = soh_i;
                        alu_op = (op3 == 6'h25) ? ALU_SLL :
                                 (op3 == 6'h26) ? ALU_SRL : ALU_SRA;
                    end
                    6'h38: begin
                        jmpl   = 1'b1;
                        rf_we  = 1'b1;
                        soh_op = soh_i;
                    end
                    6'h3C, 6'h3D: begin
                        rf_we  = 1'b1;
                        soh_op = soh_i;
                    end
                    default: ;
                endcase
            end
            2'b11: begin
                // unlisted memory op3 values stay fully zero
                unique case (op3)
                    6'h00, 6'h01, 6'h02, 6'h09, 6'h0A: begin
                        mem_en = 1'b1;
                        load   = 1'b1;
                        rf_we  = 1'b1;
                        soh_op = soh_i;
                        mem_se = op3[3];
                        mem_size = (op3 == 6'h00) ? 2'b10 :
                                   (op3 == 6'h02 || op3 == 6'h0A) ? 2'b01 : 2'b00;
                    end
                    6'h04, 6'h05, 6'h06: begin
                        mem_en = 1'b1;
                        mem_rw = 1'b1;
                        soh_op = soh_i;
                        mem_size = (op3 == 6'h04) ? 2'b10 :
                                   (op3 == 6'h06) ? 2'b01 : 2'b00;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)
            instr_signals <= '0;
        else
            instr_signals <= {jmpl, call, branch, load, rf_we, mem_en,
                              mem_rw, mem_se, mem_size, alu_op, soh_op,
                              modify_cc, rd_r15};
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vectors plus a streaming phase,
// checked through a scoreboard queue against a reference decoder.
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] instr;
    logic [18:0] instr_signals;

    int n_cmp;
    int n_bad;
    logic [18:0] sb_q[$];

    control_unit dut (
        .clk           (clk),
        .clr           (clr),
        .instr         (instr),
        .instr_signals (instr_signals)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic check(input string tag, input logic [18:0] got,
                         input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ref_dec(input logic [31:0] w);
        logic [18:0] r;
        logic [5:0]  o3;
        logic [2:0]  s;
        r  = '0;
        o3 = w[24:19];
        s  = w[13] ? 3'b001 : 3'b000;
        if (w[31:30] == 2'b01) begin
            r[17] = 1'b1; r[14] = 1'b1; r[0] = 1'b1; r[4:2] = 3'b011;
        end else if (w[31:30] == 2'b00) begin
            if (w[24:22] == 3'b010) begin
                r[16] = 1'b1; r[4:2] = 3'b100;
            end else if (w[24:22] == 3'b100 && w != 32'h0100_0000) begin
                r[14] = 1'b1; r[8:5] = 4'hE; r[4:2] = 3'b010;
            end
        end else if (w[31:30] == 2'b10) begin
            if (o3[5] == 1'b0 && (o3[3:0] <= 4'd8 || o3[3:0] == 4'd12)) begin
                r[14] = 1'b1; r[8:5] = o3[3:0]; r[1] = o3[4]; r[4:2] = s;
            end else if (o3 >= 6'h25 && o3 <= 6'h27) begin
                r[14] = 1'b1; r[4:2] = s;
                r[8:5] = (o3 == 6'h25) ? 4'hA : (o3 == 6'h26) ? 4'hB : 4'hD;
            end else if (o3 == 6'h38) begin
                r[18] = 1'b1; r[14] = 1'b1; r[4:2] = s;
            end else if (o3 == 6'h3C || o3 == 6'h3D) begin
                r[14] = 1'b1; r[4:2] = s;
            end
        end else begin
            case (o3)
                6'h00: r[15:9] = 7'b1110010;
                6'h01: r[15:9] = 7'b1110000;
                6'h02: r[15:9] = 7'b1110001;
                6'h09: r[15:9] = 7'b1110100;
                6'h0A: r[15:9] = 7'b1110101;
                6'h04: r[15:9] = 7'b0011010;
                6'h05: r[15:9] = 7'b0011000;
                6'h06: r[15:9] = 7'b0011001;
                default: r = '0;
            endcase
            if (r[13]) r[4:2] = s;
        end
        return r;
    endfunction

    task automatic apply(input string tag, input logic [31:0] w,
                         input logic c, input logic [18:0] exp);
        @(negedge clk);
        instr = w;
        clr   = c;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, instr_signals, sb_q.pop_front());
        end
    endtask

    logic [5:0] valid_op3 [0:11];

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[0]) w[24:19] = valid_op3[$urandom_range(0, 11)];
        return w;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr   = 1'b1;
        instr = 32'hDEAD_BEEF;
        valid_op3 = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06,
                      6'h09, 6'h0A, 6'h14, 6'h26, 6'h38, 6'h3C};

        apply("reset",   32'hDEAD_BEEF, 1'b1, 19'h00000);
        apply("add",     32'h8600_4002, 1'b0, 19'h04000);
        apply("ld",      32'hC400_6004, 1'b0, 19'h0E404);
        apply("stb",     32'hC428_6004, 1'b0, 19'h03004);
        apply("call",    32'h4000_0004, 1'b0, 19'h2400D);
        apply("ba",      32'h1080_0002, 1'b0, 19'h10010);
        apply("subcc",   32'h86A0_6001, 1'b0, 19'h04086);
        apply("nop",     32'h0100_0000, 1'b0, 19'h00000);
        apply("zero",    32'h0000_0000, 1'b0, 19'h00000);
        apply("op3_3f",  32'h87F8_4002, 1'b0, 19'h00000);
        apply("sethi",   32'h0700_0001, 1'b0, 19'h041C8);
        apply("ldsh",    32'hC450_4003, 1'b0, 19'h0EA00);
        apply("jmpl",    32'h81C0_6008, 1'b0, 19'h44004);
        apply("sra",     32'h8738_6002, 1'b0, 19'h041A4);
        apply("subx",    32'h8660_4002, 1'b0, 19'h04180);
        apply("st_rs2",  32'hC420_4002, 1'b0, 19'h03400);
        apply("op11_03", 32'hC418_6004, 1'b0, 19'h00000);
        apply("clr_mid", 32'h8600_4002, 1'b1, 19'h00000);

        // streaming: words change at odd times, edges fall on 2 mod 4
        @(negedge clk);
        clr = 1'b0;
        fork
            begin
                #1;
                for (int k = 0; k < 40; k++) begin
                    instr = rand_word();
                    clr   = (k == 20);
                    #6;
                end
            end
            begin
                for (int e = 0; e < 60; e++) begin
                    @(posedge clk);
                    sb_q.push_back(clr ? 19'h0 : ref_dec(instr));
                    #1;
                    check("stream", instr_signals, sb_q.pop_front());
                end
            end
        join

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Decode stage of the SPARC V8 subset pipeline.
- Takes the 32-bit instruction word fetched from instruction memory and produces a registered 19-bit bundle of control signals for the datapath: ALU, second-operand handler, register file, data memory and branch/call logic.
- Purely combinational decode feeding one output register.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  synchronous active-high reset
- instr  input  32  instruction word (bit 31 = MSB, SPARC format)
- instr_signals  output  19  registered control bundle

Behaviour:
- Clocking and reset
  - One clock (clk); reset clr is synchronous and active-high.
  - On a rising edge with clr=1, instr_signals <= 0.
  - clr=1 mid-stream discards the decode for that edge.
  - Otherwise, on each rising edge, instr_signals <= decode(instr). Latency is 1 cycle; no handshake.
- Bit map of instr_signals
  - [18] jmpl
  - [17] call
  - [16] branch
  - [15] load
  - [14] rf_we
  - [13] mem_en
  - [12] mem_rw (1=write)
  - [11] mem_se
  - [10:9] mem_size (00 byte, 01 half, 10 word)
  - [8:5] alu_op
  - [4:2] soh_op
  - [1] modify_cc
  - [0] rd_r15 (destination forced to r15)
- alu_op encoding
  - 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB, 0101 ANDN, 0110 ORN, 0111 XNOR
  - 1000 ADDX, 1100 SUBX
  - 1010 SLL, 1011 SRL, 1101 SRA
  - 1110 pass-B
- soh_op encoding
  - 000 rs2
  - 001 simm13 sign-extended
  - 010 imm22<<10
  - 011 disp30
  - 100 disp22
- Decode rules; every bit not listed is 0.
- op=01 (CALL)
  - call=1, rf_we=1, rd_r15=1, alu_op=ADD, soh=011.
- op=00, op2=010 (Bicc, any cond)
  - branch=1, soh=100.
- op=00, op2=100 (SETHI)
  - rf_we=1, alu_op=1110, soh=010.
  - Exception: instr=0x01000000 (NOP) decodes to all zeros.
- op=00, other op2 (UNIMP etc.)
  - all zeros.
- op=10, op3 in 0x00–0x08 or 0x0C, and their cc forms 0x10–0x18 or 0x1C
  - rf_we=1, alu_op=op3[3:0].
  - modify_cc=op3[4].
- op=10, op3 = 0x25 / 0x26 / 0x27
  - rf_we=1, alu_op = SLL / SRL / SRA respectively.
- op=10, op3 = 0x38 (JMPL)
  - jmpl=1, rf_we=1, alu_op=ADD.
- op=10, op3 = 0x3C / 0x3D (SAVE/RESTORE)
  - rf_we=1, alu_op=ADD.
- soh for all op=10 cases above: 001 if instr[13] (i) = 1, else 000.
- op=10, any other op3: all zeros.
- op=11 (memory), all cases:
  - mem_en=1, alu_op=ADD.
  - soh from i as for op=10.
- Loads (op=11): load=1, rf_we=1, mem_rw=0.
  - 0x00 LD: size 10
  - 0x01 LDUB: size 00
  - 0x02 LDUH: size 01
  - 0x09 LDSB: size 00, se=1
  - 0x0A LDSH: size 01, se=1
- Stores (op=11): mem_rw=1, rf_we=0.
  - 0x04 ST: size 10
  - 0x05 STB: size 00
  - 0x06 STH: size 01
- op=11, other op3: all zeros.
- Register r0 is not special-cased: rf_we is asserted even when rd=0, except for the NOP rule.
- No state beyond the output register. X on instr before memory is loaded has unspecified decode; after clr the output is 0.

Test Plan:
- Reset: clr=1 for one rising edge with any instr → instr_signals=0x00000. Then clr=0, instr=0x86004002 (ADD r1,r2,r3) → next edge 0x04000.
- Memory ops:
  - instr=0xC4006004 (LD [r1+4],r2) → 0x0E404.
  - instr=0xC4286004 (STB r2,[r1+4]) → 0x03004.
- Control flow:
  - instr=0x40000004 (CALL) → 0x2400D.
  - instr=0x10800002 (BA) → 0x10010.
- Condition codes: instr=0x86A06001 (SUBcc r1,1,r3) → 0x04086.
- NOP and undefined:
  - instr=0x01000000 → 0x00000.
  - instr=0x00000000 → 0x00000.
  - Undefined op3 0x3F under op=10 → 0x00000.
- Streaming: new word every 1.5 clocks (address +4 every 6 time units, 4-unit clock) → each output equals the decode of instr sampled at that edge; clr asserted mid-stream zeroes the output on that edge.
